pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Arbitrates three stall sources and drives per-stage freeze/flush/bubble controls:
  - data-hazard request from the hazard detector (ID stage),
  - branch-taken from EXE,
  - SRAM not-ready from the MEM stage.
- Also tracks multi-cycle memory waits, flags a memory timeout, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_stall_controller_pkg.sv | 20 ++
 rtl/pipeline_stall_controller_sat_counter.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 176 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller_pkg
//  Description : Shared constants for the pipeline stall/flush sequencer:
//                FSM state encodings and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

    // FSM state encodings (also exported on the state port)
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERROR    = 2'b10;

    // Default widths / limits
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Registered up-counter that sticks at all-ones instead of
//                wrapping. Used for the stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    // Count up on inc, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Arbitrates memory stall, branch flush and data hazard, tracks
//                multi-cycle memory waits with a timeout, and keeps saturating
//                stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,             // asynchronous, active-low
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_error,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_back,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_timeout_val = WAIT_W'(TIMEOUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              r_pend_flush;
    logic              w_pend_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic              w_mem_stall;
    logic              w_flush;

    assign w_mem_stall = mem_req & ~mem_ready;
    // A branch resolved during a memory freeze is replayed once the freeze lifts
    assign w_flush     = branch_taken | r_pend_flush;
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

    // State register together with wait counter, pending flush and timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_wait_cnt   <= '0;
            r_pend_flush <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_pend_flush <= w_pend_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    // Next-state, wait-count and pending-flush logic
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_pend_nxt    = r_pend_flush;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                    w_pend_nxt  = r_pend_flush | branch_taken;
                end else if (w_flush) begin
                    w_pend_nxt  = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    // EXE is frozen, so a held branch_taken simply re-latches
                    w_pend_nxt = r_pend_flush | branch_taken;
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc >= c_timeout_val) begin
                        w_state_nxt   = ST_ERROR;
                        w_timeout_nxt = 1'b1;
                    end
                end else begin
                    // Release cycle behaves exactly like RUN
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                    if (w_flush) begin
                        w_pend_nxt = 1'b0;
                    end
                end
            end
            ST_ERROR: begin
                if (clr_error) begin
                    w_state_nxt   = ST_RUN;
                    w_wait_nxt    = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Zero-latency control outputs; all quiet while reset is asserted
    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        freeze_back   = 1'b0;
        if (rst) begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        freeze_pc    = 1'b1;
                        freeze_if_id = 1'b1;
                        freeze_back  = 1'b1;
                    end else if (w_flush) begin
                        // Flush beats hazard: the hazarding instruction is discarded
                        flush_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                    end else if (hazard_detected) begin
                        freeze_pc     = 1'b1;
                        freeze_if_id  = 1'b1;
                        bubble_id_exe = 1'b1;
                    end
                end
                ST_ERROR: begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_back  = 1'b1;
                end
                default: begin
                    freeze_pc = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_pc),
        .value (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id),
        .value (flush_count)
    );

    assign state       = r_state;
    assign mem_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Directed self-checking bench for pipeline_stall_controller
//                (CNT_W=3, TIMEOUT=4). Inputs change 1 ns after the rising
//                edge; outputs are sampled 1 ns later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;

    // control vector order: {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back}
    localparam logic [4:0] c_idle   = 5'b00000;
    localparam logic [4:0] c_hazard = 5'b11010;
    localparam logic [4:0] c_flush  = 5'b00110;
    localparam logic [4:0] c_freeze = 5'b11001;

    logic             clk;
    logic             rst;
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_error;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             bubble_id_exe;
    logic             freeze_back;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [4:0]       w_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    assign w_ctrl = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back};

    pipeline_stall_controller #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .clr_error       (clr_error),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .flush_if_id     (flush_if_id),
        .bubble_id_exe   (bubble_id_exe),
        .freeze_back     (freeze_back),
        .mem_timeout     (mem_timeout),
        .state           (state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs and let the combinational outputs settle
    task automatic drive(input logic h, input logic b, input logic mr,
                         input logic rdy, input logic clr);
        hazard_detected = h;
        branch_taken    = b;
        mem_req         = mr;
        mem_ready       = rdy;
        clr_error       = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Reset held with random inputs: everything quiet
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check("rst_ctrl", 32'(w_ctrl), 32'(c_idle));
            check("rst_state", 32'(state), 32'd0);
        end
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check("rst_flush_cnt", 32'(flush_count), 32'd0);

        // Release with idle inputs
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("rel_ctrl", 32'(w_ctrl), 32'(c_idle));
        tick();
        check("rel_ctrl2", 32'(w_ctrl), 32'(c_idle));
        check("rel_stall_cnt", 32'(stall_cycles), 32'd0);

        // Hazard for two cycles
        drive(1, 0, 0, 0, 0);
        check("haz_ctrl1", 32'(w_ctrl), 32'(c_hazard));
        tick();
        check("haz_ctrl2", 32'(w_ctrl), 32'(c_hazard));
        check("haz_state", 32'(state), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("haz_stall_cnt", 32'(stall_cycles), 32'd2);
        check("haz_idle", 32'(w_ctrl), 32'(c_idle));

        // Branch and hazard together: flush wins
        drive(1, 1, 0, 0, 0);
        check("bh_ctrl", 32'(w_ctrl), 32'(c_flush));
        tick();
        drive(0, 0, 0, 0, 0);
        check("bh_flush_cnt", 32'(flush_count), 32'd1);
        check("bh_stall_cnt", 32'(stall_cycles), 32'd2);

        // Memory wait with branch held, then release
        drive(0, 1, 1, 0, 0);
        check("mw_ctrl_c1", 32'(w_ctrl), 32'(c_freeze));
        check("mw_state_c1", 32'(state), 32'd0);
        tick();
        check("mw_ctrl_c2", 32'(w_ctrl), 32'(c_freeze));
        check("mw_state_c2", 32'(state), 32'd1);
        tick();
        check("mw_ctrl_c3", 32'(w_ctrl), 32'(c_freeze));
        check("mw_state_c3", 32'(state), 32'd1);
        tick();
        drive(0, 1, 1, 1, 0);
        check("mw_rel_ctrl", 32'(w_ctrl), 32'(c_flush));
        check("mw_rel_state", 32'(state), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("mw_after_state", 32'(state), 32'd0);
        check("mw_after_ctrl", 32'(w_ctrl), 32'(c_idle));
        check("mw_flush_cnt", 32'(flush_count), 32'd2);
        check("mw_stall_cnt", 32'(stall_cycles), 32'd5);

        // Timeout: four stalled cycles reach ERROR
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("to_ctrl", 32'(w_ctrl), 32'(c_freeze));
            check("to_timeout_low", 32'(mem_timeout), 32'd0);
            tick();
        end
        check("to_state_err", 32'(state), 32'd2);
        check("to_flag", 32'(mem_timeout), 32'd1);
        check("to_err_ctrl", 32'(w_ctrl), 32'(c_freeze));
        check("to_stall_sat", 32'(stall_cycles), 32'd7);
        drive(0, 0, 0, 0, 0);
        check("err_idle_ctrl", 32'(w_ctrl), 32'(c_freeze));
        tick();
        check("err_hold_state", 32'(state), 32'd2);
        drive(0, 0, 0, 0, 1);
        check("clr_cycle_ctrl", 32'(w_ctrl), 32'(c_freeze));
        tick();
        drive(0, 0, 0, 0, 0);
        check("clr_state", 32'(state), 32'd0);
        check("clr_flag", 32'(mem_timeout), 32'd0);
        check("clr_ctrl", 32'(w_ctrl), 32'(c_idle));

        // clr_error outside ERROR does nothing
        drive(1, 0, 0, 0, 1);
        check("clr_run_ctrl", 32'(w_ctrl), 32'(c_hazard));
        tick();
        drive(0, 0, 0, 0, 0);
        check("clr_run_state", 32'(state), 32'd0);

        // Asynchronous reset mid-MEM_WAIT discards pending flush
        drive(0, 1, 1, 0, 0);
        tick();
        tick();
        check("ar_pre_state", 32'(state), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_ctrl", 32'(w_ctrl), 32'(c_idle));
        check("ar_stall_cnt", 32'(stall_cycles), 32'd0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("ar_rel_ctrl", 32'(w_ctrl), 32'(c_idle));
        tick();
        check("ar_flush_cnt", 32'(flush_count), 32'd0);

        // Saturation: 10 hazard cycles, 9 flush cycles
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        drive(0, 0, 0, 0, 0);
        check("sat_stall", 32'(stall_cycles), 32'd7);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        check("sat_flush_6", 32'(flush_count), 32'd6);
        for (int i = 0; i < 3; i++) tick();
        drive(0, 0, 0, 0, 0);
        check("sat_flush", 32'(flush_count), 32'd7);
        check("sat_stall_hold", 32'(stall_cycles), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
